// File: rtl/jump_controller.sv
// jump_controller: turns button levels and collision flags into tick-paced jump/gravity/left/right strobes
// using a GROUND/RISE/FALL state machine with a bounded rise.
module jump_controller #(
  parameter int RISE_TICKS = 16,
  parameter int MIN_RISE   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       jump_btn,
  input  logic       left_btn,
  input  logic       right_btn,
  input  logic       on_ground,
  input  logic       hit_ceiling,
  output logic       jump,
  output logic       gravity_on,
  output logic       left_press,
  output logic       right_press,
  output logic       airborne,
  output logic [1:0] state
);
  localparam int CW = $clog2(RISE_TICKS + 1);
  typedef enum logic [1:0] {GROUND = 2'd0, RISE = 2'd1, FALL = 2'd2} state_t;
  state_t st, st_n;
  logic [CW-1:0] rise_cnt, cnt_n, inc;
  logic btn_q, pending, pend_n, last;
  always_ff @(posedge clk) begin
    if (reset) begin
      st       <= GROUND;
      rise_cnt <= '0;
      btn_q    <= 1'b0;
      pending  <= 1'b0;
    end else begin
      st       <= st_n;
      rise_cnt <= cnt_n;
      btn_q    <= jump_btn;
      pending  <= pend_n;
    end
  end
  always_comb begin
    st_n   = st;
    cnt_n  = rise_cnt;
    inc    = rise_cnt + 1'b1;
    last   = (inc == CW'(RISE_TICKS)) || (!jump_btn && inc >= CW'(MIN_RISE));
    pend_n = pending | (jump_btn & ~btn_q & (st == GROUND));
    if (tick)
      case (st)
        // walking off a ledge wins over a pending jump
        GROUND: if (!on_ground) begin
          st_n   = FALL;
          pend_n = 1'b0;
        end else if (pending) begin
          st_n   = RISE;
          cnt_n  = '0;
          pend_n = 1'b0;
        end
        RISE:    if (hit_ceiling || last) st_n = FALL; else cnt_n = inc;
        FALL:    if (on_ground) st_n = GROUND;
        default: st_n = GROUND;
      endcase
  end
  assign jump        = ~reset & tick & (st == RISE) & ~hit_ceiling;
  assign gravity_on  = ~reset & tick & (st == FALL) & ~on_ground;
  assign left_press  = ~reset & tick & left_btn & ~right_btn;
  assign right_press = ~reset & tick & right_btn & ~left_btn;
  assign airborne    = ~reset & (st != GROUND);
  assign state       = reset ? 2'd0 : st;
endmodule

// File: tb/tb_jump_controller.sv
// tb_jump_controller: scoreboard bench; stimulus queues expected strobe vectors, a monitor pops them on each strobe.
module tb_jump_controller;
  logic clk = 1'b0, reset = 1'b1, tick = 1'b0;
  logic jump_btn = 1'b0, left_btn = 1'b0, right_btn = 1'b0, on_ground = 1'b1, hit_ceiling = 1'b0;
  logic jump, gravity_on, left_press, right_press, airborne;
  logic [1:0] state;
  int checks = 0, errors = 0;
  logic [3:0] q[$];
  localparam logic [3:0] J = 4'b1000, G = 4'b0100, L = 4'b0010, R = 4'b0001;

  jump_controller dut (
    .clk(clk), .reset(reset), .tick(tick), .jump_btn(jump_btn), .left_btn(left_btn),
    .right_btn(right_btn), .on_ground(on_ground), .hit_ceiling(hit_ceiling), .jump(jump),
    .gravity_on(gravity_on), .left_press(left_press), .right_press(right_press),
    .airborne(airborne), .state(state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic [3:0] got, e;
    got = {jump, gravity_on, left_press, right_press};
    if (reset) begin
      checks++;
      if (got != 4'b0 || airborne || state != 2'd0) begin
        errors++;
        $display("FAIL reset_quiet: got strobes=%b airborne=%b state=%0d expected all 0", got, airborne, state);
      end
    end else if (got != 4'b0) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected: got %b expected none at %0t", got, $time);
      end else begin
        e = q.pop_front();
        if (got != e) begin
          errors++;
          $display("FAIL strobe: got %b expected %b at %0t", got, e, $time);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tk(input logic [3:0] exp_v);
    if (exp_v != 4'b0) q.push_back(exp_v);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic chk_state(input string name, input logic [1:0] exp_s);
    checks++;
    if (state != exp_s || airborne != (exp_s != 2'd0)) begin
      errors++;
      $display("FAIL %s: got state=%0d airborne=%b expected state=%0d airborne=%b",
               name, state, airborne, exp_s, exp_s != 2'd0);
    end
  endtask

  task automatic drained(input string name);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d strobes missing expected 0", name, q.size());
      q.delete();
    end
  endtask

  initial begin
    tick = 1'b1; jump_btn = 1'b1; left_btn = 1'b1; right_btn = 1'b1;
    repeat (3) cyc();
    reset = 1'b0; tick = 1'b0; jump_btn = 1'b0; left_btn = 1'b0; right_btn = 1'b0;
    cyc();
    chk_state("after_reset", 2'd0);
    // full-height jump
    jump_btn = 1'b1;
    cyc();
    tk(4'b0);
    chk_state("full_rise_entry", 2'd1);
    on_ground = 1'b0;
    repeat (16) tk(J);
    chk_state("full_fall", 2'd2);
    repeat (5) tk(G);
    on_ground = 1'b1;
    tk(4'b0);
    chk_state("full_land", 2'd0);
    jump_btn = 1'b0;
    drained("full_jump");
    // press coincident with tick: latched, consumed on the next tick; then short hop
    cyc();
    jump_btn = 1'b1;
    tk(4'b0);
    chk_state("edge_on_tick", 2'd0);
    tk(4'b0);
    chk_state("hop_rise_entry", 2'd1);
    on_ground = 1'b0;
    tk(J); tk(J);
    jump_btn = 1'b0;
    tk(J); tk(J);
    chk_state("hop_fall", 2'd2);
    on_ground = 1'b1;
    tk(4'b0);
    chk_state("hop_land", 2'd0);
    drained("short_hop");
    // ceiling bump, then a mid-air press that must be discarded
    jump_btn = 1'b1;
    cyc();
    tk(4'b0);
    on_ground = 1'b0;
    tk(J); tk(J);
    hit_ceiling = 1'b1;
    tk(4'b0);
    hit_ceiling = 1'b0;
    chk_state("ceiling_fall", 2'd2);
    jump_btn = 1'b0;
    cyc();
    jump_btn = 1'b1;
    cyc();
    jump_btn = 1'b0;
    tk(G);
    on_ground = 1'b1;
    tk(4'b0);
    chk_state("ceiling_land", 2'd0);
    tk(4'b0);
    chk_state("midair_press_dropped", 2'd0);
    drained("ceiling");
    // ledge beats pending jump
    jump_btn = 1'b1;
    cyc();
    on_ground = 1'b0;
    tk(4'b0);
    chk_state("ledge_fall", 2'd2);
    tk(G);
    on_ground = 1'b1;
    tk(4'b0);
    tk(4'b0);
    chk_state("ledge_pending_cleared", 2'd0);
    jump_btn = 1'b0;
    drained("ledge");
    // horizontal
    left_btn = 1'b1;
    repeat (3) tk(L);
    right_btn = 1'b1;
    repeat (2) tk(4'b0);
    left_btn = 1'b0;
    tk(R);
    right_btn = 1'b0;
    drained("horizontal");
    // reset mid-jump
    cyc();
    jump_btn = 1'b1;
    cyc();
    tk(4'b0);
    on_ground = 1'b0;
    tk(J);
    reset = 1'b1; tick = 1'b1;
    cyc();
    reset = 1'b0; tick = 1'b0; jump_btn = 1'b0; on_ground = 1'b1;
    chk_state("reset_mid_jump", 2'd0);
    cyc();
    drained("reset_mid_jump");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
